jericalla_secuenciador: RTL and testbench

Instruction sequencer that sits directly upstream of the Jericalla datapath (ROM read ports, ALU, RAM write port). It holds a small program memory of 17-bit instruction words, loaded through a write port. On a start pulse it issues the words in order, one per cycle, on a registered instruction bus that drives the datapath. It supports stall bubbles, an optional stop-on-zero-flag mode using the datapath's ZF, and a completion flag.

---
 rtl/jericalla_secuenciador_if.sv | 31 +++
 rtl/jericalla_secuenciador.sv | 119 +++++++++++
 tb/tb_jericalla_secuenciador.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/jericalla_secuenciador_if.sv
// Sequencer bus: program load port, run control, datapath flag and
// the registered instruction stream toward the Jericalla datapath.
interface jericalla_secuenciador_if #(
    parameter int INSTR_W = 17,
    parameter int PC_W    = 4
);
    logic               cargar;
    logic [PC_W-1:0]    dir_carga;
    logic [INSTR_W-1:0] dato_carga;
    logic [PC_W-1:0]    ultima_dir;
    logic               inicio;
    logic               pausa;
    logic               parar_en_cero;
    logic               zf;
    logic [INSTR_W-1:0] instruccion;
    logic               valido;
    logic               listo;
    logic [PC_W:0]      cuenta;

    modport master (
        output cargar, dir_carga, dato_carga, ultima_dir,
        output inicio, pausa, parar_en_cero, zf,
        input  instruccion, valido, listo, cuenta
    );

    modport slave (
        input  cargar, dir_carga, dato_carga, ultima_dir,
        input  inicio, pausa, parar_en_cero, zf,
        output instruccion, valido, listo, cuenta
    );
endinterface

// File: rtl/jericalla_secuenciador.sv
// Instruction sequencer: loadable program memory issued one word per
// cycle to the datapath, with stall bubbles and stop-on-zero-flag.
module jericalla_secuenciador #(
    parameter int INSTR_W    = 17,
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = 4
) (
    input logic clk,
    input logic rst_n,
    jericalla_secuenciador_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [INSTR_W-1:0] mem [PROG_DEPTH];
    logic [PC_W-1:0]    pc, pc_nx;
    logic [PC_W-1:0]    dir_actual, dir_nx;
    logic [PC_W:0]      cuenta, cuenta_nx;
    logic [INSTR_W-1:0] instr, instr_nx;
    logic               valido, valido_nx;
    logic               listo, listo_nx;
    logic [PC_W-1:0]    ult_q, ult_nx;
    logic               stop_q, stop_nx;
    logic               fin;

    // Finish only applies to a presented word, never to a bubble.
    assign fin = valido &&
                 ((dir_actual == ult_q) || (stop_q && bus.zf));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.cargar && state != RUN) begin
            mem[bus.dir_carga] <= bus.dato_carga;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            dir_actual <= '0;
            cuenta     <= '0;
            instr      <= '0;
            valido     <= 1'b0;
            listo      <= 1'b0;
            ult_q      <= '0;
            stop_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            dir_actual <= dir_nx;
            cuenta     <= cuenta_nx;
            instr      <= instr_nx;
            valido     <= valido_nx;
            listo      <= listo_nx;
            ult_q      <= ult_nx;
            stop_q     <= stop_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        dir_nx    = dir_actual;
        cuenta_nx = cuenta;
        instr_nx  = instr;
        valido_nx = valido;
        listo_nx  = listo;
        ult_nx    = ult_q;
        stop_nx   = stop_q;
        unique case (state)
            IDLE, DONE: begin
                if (bus.inicio) begin
                    ult_nx    = bus.ultima_dir;
                    stop_nx   = bus.parar_en_cero;
                    instr_nx  = mem[0];
                    valido_nx = 1'b1;
                    dir_nx    = '0;
                    pc_nx     = PC_W'(1);
                    cuenta_nx = (PC_W+1)'(1);
                    listo_nx  = 1'b0;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (fin) begin
                    instr_nx  = '0;
                    valido_nx = 1'b0;
                    listo_nx  = 1'b1;
                    state_nx  = DONE;
                end else if (bus.pausa) begin
                    instr_nx  = '0;
                    valido_nx = 1'b0;
                end else begin
                    instr_nx  = mem[pc];
                    dir_nx    = pc;
                    valido_nx = 1'b1;
                    pc_nx     = pc + 1'b1;
                    cuenta_nx = cuenta + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.instruccion = instr;
    assign bus.valido      = valido;
    assign bus.listo       = listo;
    assign bus.cuenta      = cuenta;
endmodule

// File: tb/tb_jericalla_secuenciador.sv
// Directed bench for jericalla_secuenciador: vector table for
// plain/stalled/stop-on-zero runs plus hand-written corner sequences.
module tb_jericalla_secuenciador;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    jericalla_secuenciador_if bus ();

    jericalla_secuenciador dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        ini;
        logic        pau;
        logic        zf;
        logic        par;
        logic [3:0]  ult;
        logic [16:0] ei;
        logic        ev;
        logic        el;
        logic [4:0]  ec;
    } vec_t;

    vec_t tv [$];

    function automatic vec_t mk(logic ini, logic pau, logic zf,
                                logic par, logic [3:0] ult,
                                logic [16:0] ei, logic ev,
                                logic el, logic [4:0] ec);
        vec_t v;
        v.ini = ini; v.pau = pau; v.zf = zf; v.par = par;
        v.ult = ult; v.ei = ei; v.ev = ev; v.el = el; v.ec = ec;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(string nm, logic [16:0] ei, logic ev,
                           logic el, logic [4:0] ec);
        chk({nm, ".instr"}, 32'(bus.instruccion), 32'(ei));
        chk({nm, ".valido"}, 32'(bus.valido), 32'(ev));
        chk({nm, ".listo"}, 32'(bus.listo), 32'(el));
        chk({nm, ".cuenta"}, 32'(bus.cuenta), 32'(ec));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [3:0] a, logic [16:0] d);
        bus.cargar = 1'b1;
        bus.dir_carga = a;
        bus.dato_carga = d;
        step();
        bus.cargar = 1'b0;
    endtask

    task automatic drive(logic ini, logic pau, logic zf,
                         logic par, logic [3:0] ult);
        bus.inicio = ini;
        bus.pausa = pau;
        bus.zf = zf;
        bus.parar_en_cero = par;
        bus.ultima_dir = ult;
    endtask

    initial begin
        bus.cargar = 1'b0;
        bus.dir_carga = '0;
        bus.dato_carga = '0;
        drive(0, 0, 0, 0, 4'd0);

        #12;
        chk_out("reset", 17'h0, 0, 0, 5'd0);
        rst_n = 1'b1;
        step();

        load(4'd0, 17'h0A5F3);
        load(4'd1, 17'h12345);
        load(4'd2, 17'h1FFFF);

        // plain run; second inicio mid-run must be ignored
        tv.push_back(mk(1, 0, 0, 0, 4'd2, 17'h0A5F3, 1, 0, 5'd1));
        tv.push_back(mk(1, 0, 0, 0, 4'd2, 17'h12345, 1, 0, 5'd2));
        tv.push_back(mk(0, 0, 0, 0, 4'd2, 17'h1FFFF, 1, 0, 5'd3));
        tv.push_back(mk(0, 0, 0, 0, 4'd2, 17'h00000, 0, 1, 5'd3));
        tv.push_back(mk(0, 0, 0, 0, 4'd2, 17'h00000, 0, 1, 5'd3));
        // two stall bubbles; pausa on the finishing word is moot
        tv.push_back(mk(1, 0, 0, 0, 4'd2, 17'h0A5F3, 1, 0, 5'd1));
        tv.push_back(mk(0, 1, 0, 0, 4'd2, 17'h00000, 0, 0, 5'd1));
        tv.push_back(mk(0, 1, 0, 0, 4'd2, 17'h00000, 0, 0, 5'd1));
        tv.push_back(mk(0, 0, 0, 0, 4'd2, 17'h12345, 1, 0, 5'd2));
        tv.push_back(mk(0, 0, 0, 0, 4'd2, 17'h1FFFF, 1, 0, 5'd3));
        tv.push_back(mk(0, 1, 0, 0, 4'd2, 17'h00000, 0, 1, 5'd3));
        // single instruction run
        tv.push_back(mk(1, 0, 0, 0, 4'd0, 17'h0A5F3, 1, 0, 5'd1));
        tv.push_back(mk(0, 0, 0, 0, 4'd0, 17'h00000, 0, 1, 5'd1));
        // stop on zero flag while mem[1] is presented
        tv.push_back(mk(1, 0, 0, 1, 4'd15, 17'h0A5F3, 1, 0, 5'd1));
        tv.push_back(mk(0, 0, 0, 1, 4'd15, 17'h12345, 1, 0, 5'd2));
        tv.push_back(mk(0, 0, 1, 1, 4'd15, 17'h00000, 0, 1, 5'd2));
        tv.push_back(mk(0, 0, 0, 1, 4'd15, 17'h00000, 0, 1, 5'd2));

        foreach (tv[i]) begin
            drive(tv[i].ini, tv[i].pau, tv[i].zf, tv[i].par, tv[i].ult);
            step();
            chk_out($sformatf("vec%0d", i), tv[i].ei, tv[i].ev,
                    tv[i].el, tv[i].ec);
        end
        drive(0, 0, 0, 0, 4'd2);

        // load attempts during RUN are ignored
        drive(1, 0, 0, 0, 4'd2);
        step();
        chk_out("ldrun0", 17'h0A5F3, 1, 0, 5'd1);
        drive(0, 0, 0, 0, 4'd2);
        bus.cargar = 1'b1;
        bus.dir_carga = 4'd2;
        bus.dato_carga = 17'h00001;
        step();
        chk_out("ldrun1", 17'h12345, 1, 0, 5'd2);
        step();
        chk_out("ldrun2", 17'h1FFFF, 1, 0, 5'd3);
        bus.cargar = 1'b0;
        step();
        chk_out("ldrun3", 17'h0, 0, 1, 5'd3);
        drive(1, 0, 0, 0, 4'd2);
        step();
        drive(0, 0, 0, 0, 4'd2);
        step();
        step();
        chk_out("rerun2", 17'h1FFFF, 1, 0, 5'd3);
        step();

        // full-depth run ending at the top address
        load(4'd15, 17'h15A5A);
        drive(1, 0, 0, 0, 4'd15);
        for (int k = 0; k < 16; k++) begin
            logic [16:0] e;
            step();
            drive(0, 0, 0, 0, 4'd15);
            case (k)
                0: e = 17'h0A5F3;
                1: e = 17'h12345;
                2: e = 17'h1FFFF;
                15: e = 17'h15A5A;
                default: e = 17'h0;
            endcase
            chk_out($sformatf("full%0d", k), e, 1, 0, 5'(k + 1));
        end
        step();
        chk_out("full_end", 17'h0, 0, 1, 5'd16);

        // load and start together: start sees the old mem[0]
        bus.cargar = 1'b1;
        bus.dir_carga = 4'd0;
        bus.dato_carga = 17'h0BEEF;
        drive(1, 0, 0, 0, 4'd0);
        step();
        bus.cargar = 1'b0;
        drive(0, 0, 0, 0, 4'd0);
        chk_out("coin0", 17'h0A5F3, 1, 0, 5'd1);
        step();
        chk_out("coin1", 17'h0, 0, 1, 5'd1);
        drive(1, 0, 0, 0, 4'd0);
        step();
        drive(0, 0, 0, 0, 4'd0);
        chk_out("coin2", 17'h0BEEF, 1, 0, 5'd1);
        step();

        // asynchronous reset while mem[1] is presented
        drive(1, 0, 0, 0, 4'd2);
        step();
        drive(0, 0, 0, 0, 4'd2);
        step();
        chk_out("prerst", 17'h12345, 1, 0, 5'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rstasync", 17'h0, 0, 0, 5'd0);
        #3;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 4'd2);
        step();
        drive(0, 0, 0, 0, 4'd2);
        chk_out("post0", 17'h0, 1, 0, 5'd1);
        step();
        chk_out("post1", 17'h0, 1, 0, 5'd2);
        step();
        chk_out("post2", 17'h0, 1, 0, 5'd3);
        step();
        chk_out("post3", 17'h0, 0, 1, 5'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
